stream_mux_arb: RTL and testbench

- Parametrised N-channel, WIDTH-bit stream multiplexer with per-channel valid/ready handshake and one registered output stage.
- Three selection modes: manual select, fixed priority (lowest index wins) and round-robin.
- Used wherever several producers share one consumer. It is the clocked, back-pressure-aware successor of the team's 4:1 combinational 2-bit select mux.

---
 rtl/stream_mux_arb.sv | 110 +++++++++++
 tb/tb_stream_mux_arb.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_mux_arb.sv
// N-channel valid/ready stream mux with manual, fixed-priority and round-robin
// arbitration feeding a single registered output stage.
module stream_mux_arb #(
  parameter int WIDTH = 2,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  localparam int SELN = 1 << SELW;
  localparam logic [1:0] MODE_MANUAL = 2'd0;
  localparam logic [1:0] MODE_RR     = 2'd2;

  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [SELW-1:0]  out_ch_q;
  logic [SELW-1:0]  rr_q, rr_d;

  logic [SELN-1:0]  valid_pad;
  logic [SELN-1:0]  ready_pad;
  logic [WIDTH-1:0] ch_data [SELN];
  logic             win_vld;
  logic [SELW-1:0]  win_idx;
  logic             load_en;
  logic             xfer;
  int               rr_idx;

  // Pad to a power of two so out-of-range sel values see an invalid channel.
  assign valid_pad = SELN'(in_valid);

  for (genvar g = 0; g < SELN; g++) begin : g_pad
    if (g < N) begin : g_real
      assign ch_data[g] = in_data[g*WIDTH +: WIDTH];
    end else begin : g_void
      assign ch_data[g] = '0;
    end
  end

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    rr_idx  = 0;
    case (mode)
      MODE_MANUAL: begin
        win_vld = valid_pad[sel];
        win_idx = sel;
      end
      MODE_RR: begin
        for (int i = 0; i < N; i++) begin
          rr_idx = int'(rr_q) + i;
          if (rr_idx >= N) rr_idx = rr_idx - N;
          if (!win_vld && valid_pad[SELW'(rr_idx)]) begin
            win_vld = 1'b1;
            win_idx = SELW'(rr_idx);
          end
        end
      end
      default: begin
        for (int k = N - 1; k >= 0; k--) begin
          if (valid_pad[SELW'(k)]) begin
            win_vld = 1'b1;
            win_idx = SELW'(k);
          end
        end
      end
    endcase
  end

  assign load_en   = !out_valid_q || out_ready;
  assign xfer      = !reset && load_en && win_vld;
  assign ready_pad = xfer ? (SELN'(1) << win_idx) : '0;
  assign in_ready  = ready_pad[N-1:0];

  // Pointer wraps at N, not at 2^SELW.
  assign rr_d = (win_idx == SELW'(N - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      rr_q        <= '0;
    end else if (load_en) begin
      if (win_vld) begin
        out_data_q  <= ch_data[win_idx];
        out_ch_q    <= win_idx;
        out_valid_q <= 1'b1;
        if (mode == MODE_RR) rr_q <= rr_d;
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed self-checking bench for stream_mux_arb (WIDTH=2, N=4).
module tb_stream_mux_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] mode;
  logic [1:0] sel;
  logic [7:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [1:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_ch;

  int checks   = 0;
  int failures = 0;

  stream_mux_arb #(.WIDTH(2), .N(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 4'b0000;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; mode = 2'd2; sel = 2'd0; out_ready = 1'b1;
    in_valid = 4'b1111; in_data = {2'b11, 2'b10, 2'b11, 2'b01};
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || out_data !== 2'b00 || out_ch !== 2'd0) begin
        failures++;
        $display("FAIL reset_outputs: valid=%b data=%b ch=%0d, required 0/00/0", out_valid, out_data, out_ch);
      end
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL reset_ready: in_ready=%b, required 0000", in_ready);
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_ready: in_ready=%b, required 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'b01) begin
      failures++;
      $display("FAIL reset_first_beat: valid=%b ch=%0d data=%b, required 1/0/01", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_manual();
    mode = 2'd0; sel = 2'd2; in_valid = 4'b1111; out_ready = 1'b1;
    in_data = {2'b11, 2'b10, 2'b00, 2'b01};
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL manual_ready_sel2: in_ready=%b, required 0100", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 2'b10) begin
      failures++;
      $display("FAIL manual_beat_sel2: valid=%b ch=%0d data=%b, required 1/2/10", out_valid, out_ch, out_data);
    end
    sel = 2'd3;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL manual_ready_sel3: in_ready=%b, required 1000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 2'b11) begin
      failures++;
      $display("FAIL manual_beat_sel3: valid=%b ch=%0d data=%b, required 1/3/11", out_valid, out_ch, out_data);
    end
    // Selected channel idle while others are valid: nothing granted, output drains.
    sel = 2'd1; in_valid = 4'b1101;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL manual_idle_ready: in_ready=%b, required 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd3 || out_data !== 2'b11) begin
      failures++;
      $display("FAIL manual_drain: valid=%b ch=%0d data=%b, required 0/3/11", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_fixed_priority();
    mode = 2'd1; in_valid = 4'b1010; out_ready = 1'b1;
    in_data = {2'b11, 2'b00, 2'b10, 2'b01};
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0010) begin
        failures++;
        $display("FAIL prio_ready_c%0d: in_ready=%b, required 0010", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 2'b10) begin
        failures++;
        $display("FAIL prio_beat_c%0d: valid=%b ch=%0d data=%b, required 1/1/10", c, out_valid, out_ch, out_data);
      end
    end
    in_valid = 4'b1000;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL prio_ready_ch3: in_ready=%b, required 1000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd3 || out_data !== 2'b11) begin
      failures++;
      $display("FAIL prio_beat_ch3: valid=%b ch=%0d data=%b, required 1/3/11", out_valid, out_ch, out_data);
    end
    mode = 2'd3; in_valid = 4'b1100;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("FAIL prio_mode3_ready: in_ready=%b, required 0100", in_ready);
    end
    tick();
    checks++;
    if (out_ch !== 2'd2 || out_data !== 2'b00) begin
      failures++;
      $display("FAIL prio_mode3_beat: ch=%0d data=%b, required 2/00", out_ch, out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_all [6];
    logic [1:0] exp_sparse [4];
    exp_all    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    exp_sparse = '{2'd0, 2'd3, 2'd0, 2'd3};
    in_data = {2'b11, 2'b10, 2'b00, 2'b01};
    do_reset();
    mode = 2'd2; out_ready = 1'b1; in_valid = 4'b1111;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_all[c]) begin
        failures++;
        $display("FAIL rr_full_c%0d: valid=%b ch=%0d, required 1/%0d", c, out_valid, out_ch, exp_all[c]);
      end
    end
    // Pointer now at 2: with 1001 the search 2,3 lands on channel 3.
    in_valid = 4'b1001;
    #1;
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("FAIL rr_ptr2_ready: in_ready=%b, required 1000", in_ready);
    end
    do_reset();
    mode = 2'd2; in_valid = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== exp_sparse[c]) begin
        failures++;
        $display("FAIL rr_sparse_c%0d: valid=%b ch=%0d, required 1/%0d", c, out_valid, out_ch, exp_sparse[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_data = {2'b11, 2'b10, 2'b11, 2'b01};
    mode = 2'd0; sel = 2'd0; in_valid = 4'b0001; out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'b01) begin
      failures++;
      $display("FAIL bp_load: valid=%b ch=%0d data=%b, required 1/0/01", out_valid, out_ch, out_data);
    end
    mode = 2'd1; in_valid = 4'b0010; out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready_c%0d: in_ready=%b, required 0000", c, in_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'b01) begin
        failures++;
        $display("FAIL bp_hold_c%0d: valid=%b ch=%0d data=%b, required 1/0/01", c, out_valid, out_ch, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0010) begin
      failures++;
      $display("FAIL bp_release_ready: in_ready=%b, required 0010", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || out_data !== 2'b11) begin
      failures++;
      $display("FAIL bp_release_beat: valid=%b ch=%0d data=%b, required 1/1/11", out_valid, out_ch, out_data);
    end
    in_valid = 4'b0000;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd1 || out_data !== 2'b11) begin
      failures++;
      $display("FAIL bp_empty_hold: valid=%b ch=%0d data=%b, required 0/1/11", out_valid, out_ch, out_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_data = {2'b11, 2'b10, 2'b00, 2'b01};
    mode = 2'd2; out_ready = 1'b1; in_valid = 4'b1111;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1) begin
      failures++;
      $display("FAIL mid_setup: valid=%b ch=%0d, required 1/1", out_valid, out_ch);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (in_ready !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset_ready: in_ready=%b, required 0000", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || out_data !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset_out: valid=%b ch=%0d data=%b, required 0/0/00", out_valid, out_ch, out_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_after_ready: in_ready=%b, required 0001", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 2'b01) begin
      failures++;
      $display("FAIL mid_after_beat: valid=%b ch=%0d data=%b, required 1/0/01", out_valid, out_ch, out_data);
    end
  endtask

  initial begin
    test_reset();
    test_manual();
    test_fixed_priority();
    test_round_robin();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
